// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               FSM state encoding, datapath width, canonical NOP and the
//               OP-IMM opcode, plus a word-alignment helper for PC values.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]      OP_IMM    = 7'b0010011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } fetch_state_t;

  // Branch targets arrive unaligned-tolerant; the low two bits are forced to 0.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory request/response bundle.
//   imem_req_valid_o  fetch -> mem  request valid
//   imem_req_addr_o   fetch -> mem  word-aligned fetch address
//   imem_req_ready_i  mem -> fetch  request accepted this cycle
//   imem_resp_valid_i mem -> fetch  response valid (>=1 cycle after accept)
//   imem_resp_data_i  mem -> fetch  fetched instruction word
//   modport master : fetch-unit side; modport slave : memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
  import fetch_pkg::*;
();

  logic            imem_req_valid_o;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_req_ready_i;
  logic            imem_resp_valid_i;
  logic [XLEN-1:0] imem_resp_data_i;

  modport master (
    output imem_req_valid_o,
    output imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_resp_valid_i,
    input  imem_resp_data_i
  );

  modport slave (
    input  imem_req_valid_o,
    input  imem_req_addr_o,
    output imem_req_ready_i,
    output imem_resp_valid_i,
    output imem_resp_data_i
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register (valid, instruction, PC).
//   Update priority: flush > stall > load > bubble.
//   clk, rst_n        clock, async active-low reset
//   flush_i           clear to invalid NOP (taken branch)
//   stall_i           hold every field
//   load_i            capture instr_i / pc_i as a live instruction
//   instr_i, pc_i     incoming instruction and its PC
//   valid_o, instr_o, pc_o  registered IF/ID contents
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall_i) begin
      if (load_i) begin
        valid_d = 1'b1;
        instr_d = instr_i;
        pc_d    = pc_i;
      end else begin
        // Bubble: the PC field is left as-is, only the instruction is killed.
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RISC-V instruction-fetch stage. Owns the PC, issues one
//               outstanding fetch at a time, and loads responses into the
//               IF/ID register. A one-entry hold buffer catches a response
//               that arrives while decode is stalled on a live instruction.
//   clk, rst_n      clock, async active-low reset
//   imem            instruction-memory bundle (master side)
//   stall_i         decode stall; IF/ID holds
//   redirect_i      taken branch from EX; flushes IF/ID and in-flight fetch
//   redirect_pc_i   branch target (bits [1:0] ignored)
//   ifid_valid_o    IF/ID holds a live instruction
//   ifid_instr_o    IF/ID instruction (NOP when invalid)
//   ifid_pc_o       PC of ifid_instr_o
//   ifid_op_o       opcode field of ifid_instr_o
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [6:0]      ifid_op_o
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [XLEN-1:0] hold_instr_q;
  logic            req_valid_q;

  logic [XLEN-1:0] w_target;
  logic            w_handshake;
  logic            w_resp;
  logic            w_can_load;
  logic            w_load_mem;
  logic            w_load_hold;

  assign w_target    = word_align(redirect_pc_i);
  assign w_handshake = req_valid_q && imem.imem_req_ready_i;
  assign w_resp      = imem.imem_resp_valid_i;
  assign w_can_load  = !stall_i || !ifid_valid_o;
  assign w_load_mem  = (state_q == WAIT) && w_resp && w_can_load && !redirect_i;
  assign w_load_hold = (state_q == HOLD) && !stall_i && !redirect_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      hold_instr_q  <= NOP_INSTR;
      req_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_i) pc_q <= w_target;
          state_q     <= REQ;
          req_valid_q <= 1'b1;
        end

        REQ: begin
          if (w_handshake) begin
            inflight_pc_q <= pc_q;
            req_valid_q   <= 1'b0;
            // A branch in the accept cycle kills this fetch, and the target
            // must still be the next address requested.
            if (redirect_i) begin
              pc_q    <= w_target;
              state_q <= DROP;
            end else begin
              pc_q    <= pc_q + 32'd4;
              state_q <= WAIT;
            end
          end else if (redirect_i) begin
            pc_q <= w_target;
          end
        end

        WAIT: begin
          if (redirect_i) begin
            pc_q        <= w_target;
            state_q     <= w_resp ? REQ : DROP;
            req_valid_q <= w_resp;
          end else if (w_resp) begin
            if (w_can_load) begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
            end else begin
              hold_instr_q <= imem.imem_resp_data_i;
              state_q      <= HOLD;
            end
          end
        end

        // The killed fetch is still owed a response; swallow it before
        // issuing anything new so responses never get mismatched.
        DROP: begin
          if (redirect_i) pc_q <= w_target;
          if (w_resp) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect_i) begin
            pc_q        <= w_target;
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end else if (!stall_i) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall only protects a live instruction; an empty IF/ID may still load.
  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .stall_i (stall_i && ifid_valid_o),
    .load_i  (w_load_mem || w_load_hold),
    .instr_i (w_load_hold ? hold_instr_q : imem.imem_resp_data_i),
    .pc_i    (inflight_pc_q),
    .valid_o (ifid_valid_o),
    .instr_o (ifid_instr_o),
    .pc_o    (ifid_pc_o)
  );

  assign imem.imem_req_valid_o = req_valid_q;
  assign imem.imem_req_addr_o  = pc_q;
  assign ifid_op_o             = ifid_instr_o[6:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A memory responder with
//               configurable latency serves fetches; a transaction-level
//               model tracks expected fetch addresses, in-flight fetches and
//               IF/ID contents and is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [6:0]  ifid_op;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .ifid_valid_o  (ifid_valid),
    .ifid_instr_o  (ifid_instr),
    .ifid_pc_o     (ifid_pc),
    .ifid_op_o     (ifid_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 12) ^ 32'h0000_0463;
  endfunction

  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        hs_s = 1'b0;
  logic [31:0] hs_addr_s = '0;
  logic [31:0] resp_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      hs_s      = bus.imem_req_valid_o && bus.imem_req_ready_i;
      hs_addr_s = bus.imem_req_addr_o;
    end
  end

  initial begin
    bus.imem_resp_valid_i = 1'b0;
    bus.imem_resp_data_i  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (hs_s) begin
        mem_cnt   = mem_lat;
        resp_addr = hs_addr_s;
      end
      bus.imem_resp_valid_i = 1'b0;
      bus.imem_resp_data_i  = 32'hDEAD_BEEF;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.imem_resp_valid_i = 1'b1;
          bus.imem_resp_data_i  = mem_word(resp_addr);
        end
      end
    end
  end

  // ---------------- behavioural model + compare ----------------
  typedef struct {
    logic [31:0] addr;
    logic        live;
  } fetch_t;

  fetch_t      infl[$];
  fetch_t      popped;
  logic        m_v;
  logic [31:0] m_instr, m_pc, m_next;
  logic        held_live;
  logic [31:0] held_addr;
  logic        pw;
  logic [31:0] pw_addr;
  int          delivered = 0;

  task automatic model_reset();
    m_v       = 1'b0;
    m_instr   = NOP;
    m_pc      = '0;
    m_next    = RESET_PC;
    held_live = 1'b0;
    held_addr = '0;
    pw        = 1'b0;
    pw_addr   = '0;
    infl.delete();
  endtask

  task automatic deliver(input logic [31:0] a);
    m_v     = 1'b1;
    m_instr = mem_word(a);
    m_pc    = a;
    delivered++;
  endtask

  initial begin
    logic        hs, resp_live, cur_v;
    logic [31:0] raddr;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_valid", 32'(bus.imem_req_valid_o), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr_o, RESET_PC);
        chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("rst_ifid_instr", ifid_instr, NOP);
        chk("rst_ifid_pc", ifid_pc, 32'd0);
        chk("rst_ifid_op", 32'(ifid_op), 32'h13);
        model_reset();
      end else begin
        chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc", ifid_pc, m_pc);
        chk("ifid_op", 32'(ifid_op), 32'(m_instr[6:0]));
        hs = bus.imem_req_valid_o && bus.imem_req_ready_i;
        if (pw) begin
          chk("req_stable_valid", 32'(bus.imem_req_valid_o), 32'd1);
          chk("req_stable_addr", bus.imem_req_addr_o, pw_addr);
        end
        if (hs) begin
          chk("req_addr", bus.imem_req_addr_o, m_next);
          chk("one_outstanding", 32'(infl.size()), 32'd0);
        end

        cur_v   = m_v;
        pw      = bus.imem_req_valid_o && !bus.imem_req_ready_i;
        pw_addr = redirect ? align4(redirect_pc) : bus.imem_req_addr_o;

        resp_live = 1'b0;
        raddr     = '0;
        if (bus.imem_resp_valid_i && infl.size() > 0) begin
          popped    = infl.pop_front();
          resp_live = popped.live;
          raddr     = popped.addr;
        end
        if (hs) begin
          infl.push_back('{addr: bus.imem_req_addr_o, live: 1'b1});
          m_next = bus.imem_req_addr_o + 32'd4;
        end

        if (redirect) begin
          foreach (infl[i]) infl[i].live = 1'b0;
          held_live = 1'b0;
          m_v       = 1'b0;
          m_instr   = NOP;
          m_next    = align4(redirect_pc);
        end else if (stall && cur_v) begin
          if (resp_live) begin
            held_live = 1'b1;
            held_addr = raddr;
          end
        end else if (held_live) begin
          deliver(held_addr);
          held_live = 1'b0;
        end else if (resp_live) begin
          deliver(raddr);
        end else begin
          m_v     = 1'b0;
          m_instr = NOP;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ifid(input string name);
    int n = 0;
    while (!ifid_valid && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(ifid_valid), 32'd1);
  endtask

  task automatic wait_hs(input string name);
    int n = 0;
    while (!(bus.imem_req_valid_o && bus.imem_req_ready_i) && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(bus.imem_req_valid_o && bus.imem_req_ready_i), 32'd1);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.imem_req_valid_o && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(bus.imem_req_valid_o), 32'd1);
  endtask

  initial begin
    logic [31:0] p, ins, a;
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] p, ins, a;
    bus.imem_req_ready_i = 1'b1;

    // Reset state and first fetches
    repeat (2) @(posedge clk);
    #1;
    chk("t1_rst_valid", 32'(bus.imem_req_valid_o), 32'd0);
    chk("t1_rst_instr", ifid_instr, 32'h0000_0013);
    rst_n = 1'b1;
    step();
    chk("t1_req_valid", 32'(bus.imem_req_valid_o), 32'd1);
    chk("t1_req_addr0", bus.imem_req_addr_o, 32'h0);
    step();
    step();
    chk("t1_ifid_valid", 32'(ifid_valid), 32'd1);
    chk("t1_ifid_pc", ifid_pc, 32'h0);
    chk("t1_ifid_instr", ifid_instr, 32'h0000_0463);
    chk("t1_ifid_op", 32'(ifid_op), 32'b1100011);
    chk("t1_req_addr4", bus.imem_req_addr_o, 32'h4);

    // Stall across a response: hold buffer
    step();
    wait_ifid("t2_reach");
    p   = ifid_pc;
    ins = ifid_instr;
    stall = 1'b1;
    step();
    step();
    chk("t2_no_req_in_hold", 32'(bus.imem_req_valid_o), 32'd0);
    chk("t2_pc_held", ifid_pc, p);
    step();
    stall = 1'b0;
    chk("t2_instr_held", ifid_instr, ins);
    step();
    chk("t2_buf_valid", 32'(ifid_valid), 32'd1);
    chk("t2_buf_pc", ifid_pc, p + 32'd4);
    chk("t2_buf_instr", ifid_instr, mem_word(p + 32'd4));
    chk("t2_next_addr", bus.imem_req_addr_o, p + 32'd8);

    // Redirect in WAIT before the response
    mem_lat = 3;
    wait_hs("t3_hs");
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    chk("t3_flush_valid", 32'(ifid_valid), 32'd0);
    chk("t3_flush_instr", ifid_instr, 32'h0000_0013);
    chk("t3_drop_noreq", 32'(bus.imem_req_valid_o), 32'd0);
    step();
    step();
    chk("t3_req_valid", 32'(bus.imem_req_valid_o), 32'd1);
    chk("t3_req_addr", bus.imem_req_addr_o, 32'h0000_0100);
    mem_lat = 1;

    // Memory not ready; redirect while waiting for acceptance
    bus.imem_req_ready_i = 1'b0;
    wait_req("t4_req");
    a = bus.imem_req_addr_o;
    step();
    chk("t4_valid_stable", 32'(bus.imem_req_valid_o), 32'd1);
    chk("t4_addr_stable", bus.imem_req_addr_o, a);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("t4_addr_redir", bus.imem_req_addr_o, 32'h0000_0200);
    step();
    chk("t4_addr_redir_hold", bus.imem_req_addr_o, 32'h0000_0200);
    chk("t4_valid_hold", 32'(bus.imem_req_valid_o), 32'd1);
    step();
    bus.imem_req_ready_i = 1'b1;
    step();

    // Redirect and stall together on a live IF/ID
    wait_ifid("t5_reach");
    chk("t5_live_pc", ifid_pc, 32'h0000_0200);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    step();
    stall    = 1'b0;
    redirect = 1'b0;
    chk("t5_flush_valid", 32'(ifid_valid), 32'd0);
    chk("t5_flush_instr", ifid_instr, 32'h0000_0013);

    // Unaligned target near the top of memory; PC wraps to zero
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFB;
    step();
    redirect = 1'b0;
    wait_ifid("t6_reach0");
    chk("t6_pc_fff8", ifid_pc, 32'hFFFF_FFF8);
    step();
    wait_ifid("t6_reach1");
    chk("t6_pc_fffc", ifid_pc, 32'hFFFF_FFFC);
    step();
    wait_ifid("t6_reach2");
    chk("t6_pc_wrap", ifid_pc, 32'h0000_0000);
    chk("t6_instr_wrap", ifid_instr, 32'h0000_0463);

    // Mixed stall / backpressure / redirect pattern checked by the model
    for (int i = 0; i < 200; i++) begin
      stall                = (i % 7 == 3) || (i % 7 == 4);
      bus.imem_req_ready_i = (i % 5 != 2);
      redirect             = (i % 23 == 11);
      redirect_pc          = 32'(i * 16) + 32'h0000_1000;
      mem_lat              = ((i % 40) < 20) ? 1 : 2;
      step();
    end
    stall                = 1'b0;
    redirect             = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    mem_lat              = 3;
    repeat (6) step();
    chk("t7_progress", 32'(delivered >= 20), 32'd1);

    // Asynchronous reset in WAIT; stale response must be ignored
    wait_hs("t8_hs");
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_rst_valid", 32'(bus.imem_req_valid_o), 32'd0);
    chk("t8_rst_addr", bus.imem_req_addr_o, RESET_PC);
    chk("t8_rst_ifid_valid", 32'(ifid_valid), 32'd0);
    chk("t8_rst_ifid_instr", ifid_instr, 32'h0000_0013);
    chk("t8_rst_ifid_pc", ifid_pc, 32'h0);
    bus.imem_req_ready_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    mem_lat = 1;
    chk("t8_stale_seen", 32'(bus.imem_resp_valid_i), 32'd1);
    chk("t8_restart_valid", 32'(bus.imem_req_valid_o), 32'd1);
    chk("t8_restart_addr", bus.imem_req_addr_o, RESET_PC);
    step();
    chk("t8_stale_ignored", 32'(ifid_valid), 32'd0);
    bus.imem_req_ready_i = 1'b1;
    wait_ifid("t8_reach");
    chk("t8_pc", ifid_pc, 32'h0);
    chk("t8_instr", ifid_instr, 32'h0000_0463);

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
